// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: load-use, branch, jump and data-memory wait handling.
// Optional macro HAZ_PERF_CNT_EN adds saturating load-use / memory-stall / flush event counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_flush,
    output logic              exmem_write,
    output logic              memwb_bubble,
`ifdef HAZ_PERF_CNT_EN
    output logic [15:0]       stall_loaduse_cnt,
    output logic [15:0]       stall_mem_cnt,
    output logic [15:0]       flush_cnt,
`endif
    output logic              mem_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_next_s;
    logic       freeze_s;
    logic       mem_stall_s;
    logic       load_use_s;

    assign mem_stall_s = mem_req & ~mem_ready;
    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign load_use_s  = ex_memread & (ex_rt != {REG_AW{1'b0}}) &
                         ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    // State and wait counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= RUN;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Next-state logic and stage-control outputs.
    always_comb begin
        next_state_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        freeze_s        = 1'b0;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        ifid_flush      = 1'b0;
        idex_write      = 1'b1;
        idex_flush      = 1'b0;
        exmem_write     = 1'b1;
        memwb_bubble    = 1'b0;
        mem_err         = 1'b0;

        if (RST) begin
            next_state_s    = RUN;
            wait_cnt_next_s = 8'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_stall_s) begin
                        freeze_s        = 1'b1;
                        next_state_s    = MEM_WAIT;
                        wait_cnt_next_s = 8'd1;
                    end else begin
                        next_state_s    = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        next_state_s    = RUN;
                        wait_cnt_next_s = 8'd0;
                    end else begin
                        freeze_s        = 1'b1;
                        wait_cnt_next_s = wait_cnt_r + 8'd1;
                        if (wait_cnt_r == MAX_WAIT_C) begin
                            next_state_s = ERR;
                        end else begin
                            next_state_s = MEM_WAIT;
                        end
                    end
                end
                ERR: begin
                    freeze_s     = 1'b1;
                    next_state_s = ERR;
                end
                default: begin
                    freeze_s     = 1'b1;
                    next_state_s = ERR;
                end
            endcase
        end

        // Branch/load-use/jump are only looked at when the pipeline is not frozen.
        if (RST) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze_s) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            mem_err      = (state_r != RUN) && (state_r != MEM_WAIT);
        end else if (ex_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (load_use_s) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_flush   = 1'b1;
        end else if (id_jump) begin
            ifid_flush   = 1'b1;
        end else begin
            pc_write     = 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic ev_mem_s;
    logic ev_lu_s;
    logic ev_fl_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            sat_inc = v + 16'd1;
        end else begin
            sat_inc = v;
        end
    endfunction

    assign ev_mem_s = ~RST & (((state_r == RUN) & mem_stall_s) |
                              ((state_r == MEM_WAIT) & ~mem_ready));
    assign ev_fl_s  = ~RST & ~freeze_s & (ex_branch_taken | (~load_use_s & id_jump));
    assign ev_lu_s  = ~RST & ~freeze_s & ~ex_branch_taken & load_use_s;

    // Saturating per-event counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_loaduse_cnt <= 16'd0;
            stall_mem_cnt     <= 16'd0;
            flush_cnt         <= 16'd0;
        end else begin
            stall_loaduse_cnt <= sat_inc(stall_loaduse_cnt, ev_lu_s);
            stall_mem_cnt     <= sat_inc(stall_mem_cnt, ev_mem_s);
            flush_cnt         <= sat_inc(flush_cnt, ev_fl_s);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: constant vector table, hand-written wait/timeout sequences,
// and random stimulus against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int MAXW = 4;

    // Output vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble, mem_err
    localparam logic [7:0] A_RESET  = 8'b0010_1010;
    localparam logic [7:0] A_NONE   = 8'b1101_0100;
    localparam logic [7:0] A_FREEZE = 8'b0000_0010;
    localparam logic [7:0] A_ERR    = 8'b0000_0011;
    localparam logic [7:0] A_BRANCH = 8'b1111_1100;
    localparam logic [7:0] A_LU     = 8'b0001_1100;
    localparam logic [7:0] A_JUMP   = 8'b1111_0100;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic       jump;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic       req;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_jump, ex_memread, ex_branch_taken, mem_req, mem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic       exmem_write, memwb_bubble, mem_err;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_loaduse_cnt, stall_mem_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    bit m_wait;
    bit m_err;
    int m_frozen;

    logic [7:0] out_vec;
    assign out_vec = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                      exmem_write, memwb_bubble, mem_err};

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.REG_AW(5), .MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RST(RST),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_bubble(memwb_bubble),
`ifdef HAZ_PERF_CNT_EN
        .stall_loaduse_cnt(stall_loaduse_cnt), .stall_mem_cnt(stall_mem_cnt),
        .flush_cnt(flush_cnt),
`endif
        .mem_err(mem_err)
    );

    function automatic vec_t mk(string n, logic rst, logic [4:0] rs, logic [4:0] rt, logic ut,
                                logic j, logic mr, logic [4:0] ert, logic br, logic req,
                                logic rdy, logic [7:0] exp);
        vec_t v;
        v.name = n; v.rst = rst; v.rs = rs; v.rt = rt; v.ut = ut; v.jump = j;
        v.mr = mr; v.ert = ert; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    // Drive one cycle, compare combinational outputs mid-cycle, then move past the edge.
    task automatic apply(input vec_t v);
        RST = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.ut; id_jump = v.jump;
        ex_memread = v.mr; ex_rt = v.ert; ex_branch_taken = v.br;
        mem_req = v.req; mem_ready = v.rdy;
        @(negedge CLK);
        total++;
        if (out_vec !== v.exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", v.name, out_vec, v.exp);
        end
        @(posedge CLK);
        #1;
    endtask

    // Reference: a pending access freezes everything; more than MAXW frozen cycles is fatal.
    task automatic model(input vec_t v, output logic [7:0] e);
        bit lu;
        lu = v.mr && (v.ert != 5'd0) && ((v.ert == v.rs) || (v.ut && (v.ert == v.rt)));
        if (v.rst) begin
            e = A_RESET; m_wait = 0; m_frozen = 0; m_err = 0;
        end else if (m_err) begin
            e = A_ERR;
        end else if (!v.rdy && (m_wait || v.req)) begin
            e = A_FREEZE;
            m_frozen = m_frozen + 1;
            m_wait = 1;
            if (m_frozen > MAXW) begin
                m_err = 1; m_wait = 0;
            end
        end else begin
            m_wait = 0; m_frozen = 0;
            if (v.br)      e = A_BRANCH;
            else if (lu)   e = A_LU;
            else if (v.jump) e = A_JUMP;
            else           e = A_NONE;
        end
    endtask

    vec_t vecs[14];
    vec_t r;
    logic [7:0] e;

    initial begin
        vecs[0]  = mk("reset0",        1, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_RESET);
        vecs[1]  = mk("reset1",        1, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_RESET);
        vecs[2]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_NONE);
        vecs[3]  = mk("lu_rs",         0, 8, 0, 0, 0, 1, 8, 0, 0, 0, A_LU);
        vecs[4]  = mk("lu_gone",       0, 8, 0, 0, 0, 0, 8, 0, 0, 0, A_NONE);
        vecs[5]  = mk("lu_r0",         0, 0, 0, 1, 0, 1, 0, 0, 0, 0, A_NONE);
        vecs[6]  = mk("lu_rt_unused",  0, 3, 8, 0, 0, 1, 8, 0, 0, 0, A_NONE);
        vecs[7]  = mk("lu_rt_used",    0, 3, 8, 1, 0, 1, 8, 0, 0, 0, A_LU);
        vecs[8]  = mk("br_over_lu",    0, 9, 0, 0, 0, 1, 9, 1, 0, 0, A_BRANCH);
        vecs[9]  = mk("jump",          0, 0, 0, 0, 1, 0, 0, 0, 0, 0, A_JUMP);
        vecs[10] = mk("lu_over_jump",  0, 4, 0, 0, 1, 1, 4, 0, 0, 0, A_LU);
        vecs[11] = mk("br_over_jump",  0, 0, 0, 0, 1, 0, 0, 1, 0, 0, A_BRANCH);
        vecs[12] = mk("mem_fast_jump", 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, A_JUMP);
        vecs[13] = mk("lu_miss",       0, 6, 0, 0, 0, 1, 5, 0, 0, 0, A_NONE);
        for (int i = 0; i < 14; i++) apply(vecs[i]);

        // Memory wait of 3 frozen cycles with a pending jump held off until release.
        for (int i = 0; i < 3; i++) apply(mk("wait_freeze", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, A_FREEZE));
        apply(mk("wait_release", 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, A_JUMP));
        apply(mk("after_release", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_NONE));

        // Timeout: 5 frozen cycles then sticky error until reset.
        for (int i = 0; i < MAXW + 1; i++) apply(mk("to_freeze", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_FREEZE));
        apply(mk("to_err", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_ERR));
        apply(mk("to_err_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, A_ERR));
        apply(mk("to_err_branch", 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, A_ERR));
        apply(mk("to_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_RESET));
        apply(mk("to_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_NONE));

        // Random stimulus against the reference model.
        for (int i = 0; i < 600; i++) begin
            r = mk("rand", (i == 0) || ($urandom_range(0, 39) == 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'd0);
            model(r, e);
            r.exp = e;
            apply(r);
        end

`ifdef HAZ_PERF_CNT_EN
        apply(mk("pc_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_RESET));
        apply(mk("pc_lu1", 0, 8, 0, 0, 0, 1, 8, 0, 0, 0, A_LU));
        apply(mk("pc_idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_NONE));
        apply(mk("pc_lu2", 0, 8, 0, 0, 0, 1, 8, 0, 0, 0, A_LU));
        for (int i = 0; i < 3; i++) apply(mk("pc_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_FREEZE));
        apply(mk("pc_release", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, A_NONE));
        apply(mk("pc_branch", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, A_BRANCH));
        apply(mk("pc_idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_NONE));
        total++;
        if (stall_loaduse_cnt !== 16'd2) begin
            bad++; $display("FAIL cnt_loaduse: got %0d want 2", stall_loaduse_cnt);
        end
        total++;
        if (stall_mem_cnt !== 16'd3) begin
            bad++; $display("FAIL cnt_mem: got %0d want 3", stall_mem_cnt);
        end
        total++;
        if (flush_cnt !== 16'd1) begin
            bad++; $display("FAIL cnt_flush: got %0d want 1", flush_cnt);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Gates the PC and the IFID, IDEX and EXMEM pipeline registers, and injects bubbles.
- Detects load-use hazards, taken branches (resolved in EX) and jumps (resolved in ID).
- Freezes the whole pipeline while the data memory port is busy, with a wait timeout.

Parameters:
REG_AW, 5, register-address width (rs/rt/rd fields)
MAX_WAIT, 15, max consecutive MEM_WAIT cycles before entering ERR (range 1..255)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous reset, active-high
id_rs  in  REG_AW  RA field of the instruction in ID
id_rt  in  REG_AW  RB field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
id_jump  in  1  ID control jump bit (op 000010)
ex_memread  in  1  EX control memread bit (lw, op 100011)
ex_rt  in  REG_AW  destination rt of the instruction in EX
ex_branch_taken  in  1  beq in EX and operands equal
mem_req  in  1  MEM stage issuing a load or store this cycle
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IFID register enable
ifid_flush  out  1  clear IFID to nop on the next edge
idex_write  out  1  IDEX register enable
idex_flush  out  1  load a bubble into IDEX (all ctrl bits 0)
exmem_write  out  1  EXMEM register enable
memwb_bubble  out  1  load a bubble into MEMWB
mem_err  out  1  sticky timeout flag

Behaviour:
- States: RUN, MEM_WAIT, ERR. 2-bit state register plus 8-bit wait_cnt, both updated on posedge CLK.
- Outputs are combinational from state and inputs. With RST high they are forced to the reset values listed below.
- RST high: next state RUN, wait_cnt=0, mem_err=0.
  - Reset output values: pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, ifid_flush=1, idex_flush=1, memwb_bubble=1.
  - Reset mid-MEM_WAIT or in ERR aborts the wait with no further effect.
- Default in RUN (no event): all *_write=1, all flush/bubble=0.
- Event priority in RUN, highest first:
  1. Memory stall: mem_req & ~mem_ready.
     - pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1.
     - next state MEM_WAIT, wait_cnt<=1.
     - Branch, jump and load-use conditions are ignored this cycle; they are re-evaluated after release because stage contents are frozen.
  2. Branch taken: ex_branch_taken=1.
     - ifid_flush=1, idex_flush=1, pc_write=1 (PC takes the branch target).
     - A coincident jump or load-use is squashed by the flush.
  3. Load-use: ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
     - pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle.
     - On the next cycle the load is in MEM, so the condition is naturally false.
  4. Jump: id_jump=1 -> ifid_flush=1, pc_write=1.
- mem_req & mem_ready in the same RUN cycle: zero stall cycles.
- MEM_WAIT:
  - Full freeze as in event 1, with memwb_bubble=1.
  - mem_ready=1: release this cycle (all outputs at RUN defaults; branch/load-use/jump evaluated normally), next state RUN, wait_cnt<=0.
  - Otherwise wait_cnt<=wait_cnt+1. If wait_cnt==MAX_WAIT and ~mem_ready: next state ERR.
- ERR: full freeze, memwb_bubble=1, mem_err=1. Left only by RST. Inputs are ignored.
- rs/rt compare with register 0 never raises a hazard.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds three 16-bit output ports stall_loaduse_cnt, stall_mem_cnt, flush_cnt. Each increments once per cycle in which its condition is the active (winning) event; MEM_WAIT cycles count as mem. All three saturate at 16'hFFFF and clear on RST.
- Undefined: ports and counters are absent; remaining behaviour is identical.

Test Plan:
- Reset: RST=1 for 2 cycles with mem_req=1 -> pc_write=0, idex_flush=1, mem_err=0; first cycle after RST low, all inputs 0 -> all *_write=1, all flush/bubble=0.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_flush=1. Same stimulus with ex_rt=0, or with id_rt=8 and id_uses_rt=0 -> no stall.
- Branch + load-use same cycle: ex_branch_taken=1, ex_memread=1, ex_rt=id_rs=9 -> ifid_flush=1, idex_flush=1, pc_write=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> 3 freeze cycles with memwb_bubble=1; release in the 4th cycle; state RUN afterwards. Coincident id_jump=1 during the freeze has no effect until release.
- Timeout: MAX_WAIT=4, mem_ready held 0 -> ERR entered after 5 frozen cycles; mem_err=1 and held while mem_ready later goes 1; cleared only by RST.
- HAZ_PERF_CNT_EN: 2 load-use stalls, 3 memory-wait cycles and 1 branch flush -> counters read 2/3/1. Preloaded near limit -> stall_mem_cnt sticks at 16'hFFFF.
